// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner front end.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN = 2'd0, EVAL = 2'd1, WAIT_READ = 2'd2} scan_state_e;

  function automatic int key_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Linear indices (c*4 + r) of the calculator function keys on the 4x4 pad.
  localparam int KEY_SIGN = 3;
  localparam int KEY_ADD  = 12;
  localparam int KEY_SUB  = 13;
  localparam int KEY_MUL  = 14;
  localparam int KEY_EQ   = 15;
endpackage

// File: rtl/keypad_onehot_enc.sv
// Classifies an active-low key snapshot as none/single/multi and encodes the lowest pressed index.
module keypad_onehot_enc
  import keypad_pkg::*;
#(
  parameter int N  = 16,
  parameter int KW = key_w(N, 1)
) (
  input  logic [N-1:0]  snap,
  output logic          zero,
  output logic          single,
  output logic          multi,
  output logic [KW-1:0] idx
);
  logic [N-1:0] pressed;

  assign pressed = ~snap;
  assign zero    = ~|pressed;
  // Clearing the lowest set bit leaves something only when two or more keys are down.
  assign multi   = |(pressed & (pressed - N'(1)));
  assign single  = ~zero & ~multi;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pressed[i]) idx = KW'(i);
  end
endmodule

// File: rtl/keypad_scanner_param.sv
// Matrix keypad scanner/debouncer with KeyRdy/KeyRd handshake.
// Optional auto-repeat of a held key when KEY_REPEAT_EN is defined.
module keypad_scanner_param
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SETTLE       = 1,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_SCANS = 32,
  localparam int KW          = key_w(ROWS, COLS),
  localparam int N           = ROWS * COLS
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [ROWS-1:0] RowIn,
  output logic [COLS-1:0] ColOut,
  output logic            KeyRdy,
  input  logic            KeyRd,
  output logic [KW-1:0]   KeyCode,
  output logic            ScanBusy
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  scan_state_e   state, state_nx;
  logic [CW-1:0] col;
  logic [3:0]    settle_cnt;
  logic [N-1:0]  snap;
  logic [KW-1:0] cand;
  logic [3:0]    cnt, cnt_nx;
  logic          released;
  logic          zero, single, multi;
  logic [KW-1:0] idx;
  logic          settle_done, last_col;
  logic          same_key, cnt_sat, report, rep_hit, fire;

  keypad_onehot_enc #(.N(N), .KW(KW)) u_enc (
    .snap   (snap),
    .zero   (zero),
    .single (single),
    .multi  (multi),
    .idx    (idx)
  );

  assign settle_done = settle_cnt == 4'(SETTLE);
  assign last_col    = col == CW'(COLS - 1);

  // A saturated count on the same key must not look like a fresh arrival at DEBOUNCE.
  always_comb begin
    same_key = single && released && (idx == cand);
    cnt_sat  = cnt == 4'(DEBOUNCE);
    cnt_nx   = same_key ? (cnt_sat ? cnt : cnt + 4'd1) : 4'd1;
    report   = single && released && (cnt_nx == 4'(DEBOUNCE)) && !(same_key && cnt_sat);
    fire     = report || rep_hit;
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_cnt;

  assign rep_hit = same_key && cnt_sat && (rep_cnt == RW'(REPEAT_SCANS - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) rep_cnt <= '0;
    else if (state == EVAL)
      rep_cnt <= (same_key && cnt_sat && !rep_hit) ? rep_cnt + RW'(1) : '0;
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= SCAN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SCAN:      if (settle_done && last_col) state_nx = EVAL;
      EVAL:      state_nx = fire ? WAIT_READ : SCAN;
      WAIT_READ: if (KeyRd && KeyRdy) state_nx = SCAN;
      default:   state_nx = SCAN;
    endcase
  end

  // col is parked at 0 outside SCAN, so column 0 stays driven while waiting.
  always_comb begin
    ColOut   = ~(COLS'(1) << col);
    ScanBusy = state != WAIT_READ;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col        <= '0;
      settle_cnt <= '0;
      snap       <= '1;
      cand       <= '0;
      cnt        <= '0;
      released   <= 1'b0;
      KeyRdy     <= 1'b0;
      KeyCode    <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (settle_done) begin
            settle_cnt <= '0;
            for (int c = 0; c < COLS; c++)
              if (col == CW'(c)) snap[c*ROWS +: ROWS] <= RowIn;
            col <= last_col ? '0 : col + CW'(1);
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        EVAL: begin
          if (zero) begin
            released <= 1'b1;
            cnt      <= '0;
          end else if (multi) begin
            released <= 1'b0;
            cnt      <= '0;
          end else if (released) begin
            cand <= idx;
            cnt  <= cnt_nx;
            if (fire) begin
              KeyRdy  <= 1'b1;
              KeyCode <= idx;
            end
          end
        end
        WAIT_READ: begin
          if (KeyRd && KeyRdy) begin
            KeyRdy <= 1'b0;
`ifndef KEY_REPEAT_EN
            released <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner_param.sv
// Directed bench for keypad_scanner_param at default parameters with a modelled 4x4 key matrix.
module tb_keypad_scanner_param;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        KeyRd = 1'b0;
  logic [3:0]  RowIn;
  logic [3:0]  ColOut;
  logic        KeyRdy;
  logic [3:0]  KeyCode;
  logic        ScanBusy;
  logic [15:0] pressed = '0;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  keypad_scanner_param dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .RowIn    (RowIn),
    .ColOut   (ColOut),
    .KeyRdy   (KeyRdy),
    .KeyRd    (KeyRd),
    .KeyCode  (KeyCode),
    .ScanBusy (ScanBusy)
  );

  always #5 Clock = ~Clock;

  // Closed switch at (c,r) pulls row r low while column c is driven low.
  always_comb begin
    RowIn = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!ColOut[c] && pressed[c*4+r]) RowIn[r] = 1'b0;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset values
    cyc(2);
    chk("rst_colout", ColOut, 4'b1110);
    chk("rst_rdy", KeyRdy, 1'b0);
    chk("rst_code", KeyCode, 4'd0);
    chk("rst_busy", ScanBusy, 1'b1);
    Reset = 1'b0;

    // Column walk over the first scan, then a second all-released scan
    cyc(2); chk("col1", ColOut, 4'b1101);
    cyc(2); chk("col2", ColOut, 4'b1011);
    cyc(2); chk("col3", ColOut, 4'b0111);
    cyc(2); chk("eval_col", ColOut, 4'b1110);
    chk("eval_busy", ScanBusy, 1'b1);
    cyc(10);
    chk("idle_rdy", KeyRdy, 1'b0);

    // Press idx 9 (col 2, row 1): report one cycle after the 4th EVAL
    pressed[9] = 1'b1;
    cyc(35); chk("pre_deb_rdy", KeyRdy, 1'b0);
    cyc(1);
    chk("deb_rdy", KeyRdy, 1'b1);
    chk("deb_code", KeyCode, 4'd9);
    chk("wait_colout", ColOut, 4'b1110);
    chk("wait_busy", ScanBusy, 1'b0);
    cyc(5);
    chk("hold_rdy", KeyRdy, 1'b1);
    chk("hold_code", KeyCode, 4'd9);

    // Ack, keep holding: no second report until released
    KeyRd = 1'b1; cyc(1); KeyRd = 1'b0;
    chk("ack_rdy", KeyRdy, 1'b0);
    chk("ack_busy", ScanBusy, 1'b1);
    cyc(180); chk("held_norpt", KeyRdy, 1'b0);
    pressed = '0; cyc(9);
    pressed[9] = 1'b1;
    cyc(35); chk("repress_pre", KeyRdy, 1'b0);
    cyc(1);
    chk("repress_rdy", KeyRdy, 1'b1);
    chk("repress_code", KeyCode, 4'd9);

    // Chord idx 0+5 with KeyRd left high (ignored while KeyRdy is low)
    KeyRd = 1'b1; cyc(1);
    pressed = 16'h0021; cyc(90);
    chk("chord_rdy", KeyRdy, 1'b0);
    KeyRd = 1'b0;
    pressed = 16'h0001; cyc(36);
    chk("chord_norel", KeyRdy, 1'b0);
    pressed = '0; cyc(9);
    pressed = 16'h0001;
    cyc(35); chk("idx0_pre", KeyRdy, 1'b0);
    cyc(1);
    chk("idx0_rdy", KeyRdy, 1'b1);
    chk("idx0_code", KeyCode, 4'd0);

    // Bounce on idx 3 for 8 scans, then stable
    KeyRd = 1'b1; cyc(1); KeyRd = 1'b0;
    pressed = '0; cyc(9);
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      cyc(9);
    end
    chk("bounce_rdy", KeyRdy, 1'b0);
    pressed = 16'h0008;
    cyc(35); chk("stable_pre", KeyRdy, 1'b0);
    cyc(1);
    chk("stable_rdy", KeyRdy, 1'b1);
    chk("stable_code", KeyCode, 4'd3);
    KeyRd = 1'b1; cyc(1); KeyRd = 1'b0;
    cyc(45); chk("one_report", KeyRdy, 1'b0);

    // Reset mid-debounce (cnt=3, column 1), key held through reset release
    pressed = '0; cyc(9);
    pressed = 16'h0200; cyc(27);
    cyc(3); chk("mid_colout", ColOut, 4'b1101);
    Reset = 1'b1; #1;
    chk("arst_rdy", KeyRdy, 1'b0);
    chk("arst_colout", ColOut, 4'b1110);
    chk("arst_busy", ScanBusy, 1'b1);
    chk("arst_code", KeyCode, 4'd0);
    cyc(1); Reset = 1'b0;
    cyc(54); chk("held_rst_rdy", KeyRdy, 1'b0);
    pressed = '0; cyc(9);
    pressed = 16'h0200;
    cyc(35); chk("post_rst_pre", KeyRdy, 1'b0);
    cyc(1);
    chk("post_rst_rdy", KeyRdy, 1'b1);
    chk("post_rst_code", KeyCode, 4'd9);
    KeyRd = 1'b1; cyc(1); KeyRd = 1'b0;
    chk("final_ack", KeyRdy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
